// File: rtl/hrav_bank_dispatch_if.sv
// AXI-Stream bundle with C_LANES parallel lanes, flattened lane-major.
// The dispatcher uses a 1-lane slave on its input and a C_NUM_BANKS-lane master on its output.
interface hrav_bank_dispatch_if #(
  parameter int C_DATA_WIDTH  = 256,
  parameter int C_TUSER_WIDTH = 128,
  parameter int C_LANES       = 1
);
  logic [C_LANES*C_DATA_WIDTH-1:0]     tdata;
  logic [C_LANES*(C_DATA_WIDTH/8)-1:0] tstrb;
  logic [C_LANES*C_TUSER_WIDTH-1:0]    tuser;
  logic [C_LANES-1:0]                  tvalid;
  logic [C_LANES-1:0]                  tlast;
  logic [C_LANES-1:0]                  tready;

  modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/hrav_bank_dispatch.sv
// Packet dispatcher: steers whole AXI-Stream packets to one, a pinned, or all banks
// through a single shared holding register with per-bank pending bits.
module hrav_bank_dispatch #(
  parameter int C_DATA_WIDTH  = 256,
  parameter int C_TUSER_WIDTH = 128,
  parameter int C_NUM_BANKS   = 3,
  parameter int C_CNT_WIDTH   = 32
) (
  input  logic                             axi_aclk,
  input  logic                             axi_resetn,
  input  logic [1:0]                       mode,
  input  logic [2:0]                       masterbank_sel_pin,
  hrav_bank_dispatch_if.slave              s_axis,
  hrav_bank_dispatch_if.master             m_axis,
  output logic [C_CNT_WIDTH*C_NUM_BANKS-1:0] bank_pkt_cnt,
  output logic [C_CNT_WIDTH-1:0]           drop_cnt,
  output logic [2:0]                       cur_bank
);
  localparam int NB = C_NUM_BANKS;
  localparam int SW = C_DATA_WIDTH / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FWD  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [NB-1:0]          dest_q, dest_d;
  logic [NB-1:0]          pend_q, pend_d;
  logic                   rr_q, rr_d;
  logic [2:0]             cur_bank_q, cur_bank_d;
  logic [C_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  logic [C_DATA_WIDTH-1:0]  tdata_q;
  logic [SW-1:0]            tstrb_q;
  logic [C_TUSER_WIDTH-1:0] tuser_q;
  logic                     tlast_q;

  logic [NB-1:0] first_mask, fwd_mask, retire;
  logic          first_drop, pkt_drop, sel_ok;
  logic          hold_free, in_ready, accept, load, is_last, rr_pkt;

  assign retire    = pend_q & m_axis.tready;
  // Holding register may be overwritten when every pending bank retires this cycle.
  assign hold_free = ((pend_q & ~m_axis.tready) == '0);
  assign in_ready  = axi_resetn & ((state_q == ST_DROP) | hold_free);
  assign accept    = s_axis.tvalid[0] & in_ready;
  assign is_last   = s_axis.tlast[0];
  assign sel_ok    = ({1'b0, masterbank_sel_pin} < 4'(NB));

  assign s_axis.tready = in_ready;

  always_comb begin
    first_mask = '0;
    first_drop = 1'b0;
    case (mode)
      2'd0: begin
        for (int b = 0; b < NB; b++) first_mask[b] = (cur_bank_q == 3'(b));
      end
      2'd2: first_mask = '1;
      default: begin
        if (sel_ok) begin
          for (int b = 0; b < NB; b++) first_mask[b] = (masterbank_sel_pin == 3'(b));
        end else begin
          first_drop = 1'b1;
        end
      end
    endcase
  end

  assign fwd_mask = (state_q == ST_IDLE) ? first_mask : dest_q;
  assign pkt_drop = (state_q == ST_DROP) | ((state_q == ST_IDLE) & first_drop);
  assign load     = accept & ~pkt_drop;
  assign rr_pkt   = (state_q == ST_IDLE) ? (mode == 2'd0) : ((state_q == ST_FWD) & rr_q);

  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    rr_d       = rr_q;
    cur_bank_d = cur_bank_q;
    drop_cnt_d = drop_cnt_q;
    pend_d     = load ? fwd_mask : (pend_q & ~m_axis.tready);
    if (accept) begin
      if (state_q == ST_IDLE) begin
        dest_d = first_mask;
        rr_d   = (mode == 2'd0);
        if (!is_last) state_d = first_drop ? ST_DROP : ST_FWD;
      end else if (is_last) begin
        state_d = ST_IDLE;
      end
      if (is_last) begin
        if (pkt_drop) drop_cnt_d = drop_cnt_q + 1'b1;
        if (rr_pkt) cur_bank_d = (cur_bank_q == 3'(NB - 1)) ? 3'd0 : cur_bank_q + 3'd1;
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      state_q    <= ST_IDLE;
      dest_q     <= '0;
      pend_q     <= '0;
      rr_q       <= 1'b0;
      cur_bank_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      dest_q     <= dest_d;
      pend_q     <= pend_d;
      rr_q       <= rr_d;
      cur_bank_q <= cur_bank_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Payload needs no reset: it is only observed while a pending bit is set.
  always_ff @(posedge axi_aclk) begin
    if (load) begin
      tdata_q <= s_axis.tdata;
      tstrb_q <= s_axis.tstrb;
      tuser_q <= s_axis.tuser;
      tlast_q <= is_last;
    end
  end

  for (genvar gi = 0; gi < NB; gi++) begin : g_bank
    logic [C_CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge axi_aclk) begin
      if (!axi_resetn) cnt_q <= '0;
      else if (retire[gi] & tlast_q) cnt_q <= cnt_q + 1'b1;
    end

    assign bank_pkt_cnt[gi*C_CNT_WIDTH +: C_CNT_WIDTH]    = cnt_q;
    assign m_axis.tdata[gi*C_DATA_WIDTH +: C_DATA_WIDTH]  = tdata_q;
    assign m_axis.tstrb[gi*SW +: SW]                      = tstrb_q;
    assign m_axis.tuser[gi*C_TUSER_WIDTH +: C_TUSER_WIDTH] = tuser_q;
    assign m_axis.tlast[gi]                               = tlast_q;
  end

  assign m_axis.tvalid = pend_q;
  assign drop_cnt      = drop_cnt_q;
  assign cur_bank      = cur_bank_q;
endmodule
